// File: rtl/aes_iter_core_if.sv
// Request/response bundle for aes_iter_core.
// Carries err only when AES_ERR_EN is defined.
interface aes_iter_core_if #(
   parameter int MAX_KEY_BITS = 256
);
   logic                    in_valid;
   logic                    in_ready;
   logic [1:0]              key_size;
   logic [127:0]            in_data;
   logic [MAX_KEY_BITS-1:0] in_key;
   logic                    out_valid;
   logic                    out_ready;
   logic [127:0]            out_data;
   logic                    busy;
`ifdef AES_ERR_EN
   logic                    err;

   modport master (
      output in_valid, key_size, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_data, busy, err
   );
   modport slave (
      input  in_valid, key_size, in_data, in_key, out_ready,
      output in_ready, out_valid, out_data, busy, err
   );
`else
   modport master (
      output in_valid, key_size, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_data, busy
   );
   modport slave (
      input  in_valid, key_size, in_data, in_key, out_ready,
      output in_ready, out_valid, out_data, busy
   );
`endif
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryptor, one round per clock.
// Optional AES_ERR_EN: illegal key sizes return err instead of remapping.
module aes_iter_core #(
   parameter int MAX_KEY_BITS = 256
) (
   input logic            clk,
   input logic            rst_n,
   aes_iter_core_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   localparam logic [1:0] MAX_SZ =
      (MAX_KEY_BITS >= 256) ? 2'd2 :
      (MAX_KEY_BITS >= 192) ? 2'd1 : 2'd0;

   fsm_t         fsm;
   logic [3:0]   rnd;
   logic [1:0]   ks;
   logic [2:0]   ph;
   logic [7:0]   rcon;
   logic [127:0] st;
   logic [31:0]  win [8];
   logic         rdy, vld, bsy;
   logic [3:0]   nk, nr;
   logic [1:0]   req;
   logic [255:0] k256, kl;
   logic [31:0]  g [4];
   logic [31:0]  cat [12];
   logic [127:0] rk, nxt;
   logic [2:0]   ph_nxt;
   logic         rot_any;
`ifdef AES_ERR_EN
   logic         bad, err;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] t, r;
      t = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         t = gmul(t, t);
         r = gmul(r, t);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^
             {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   assign nk = 4'd4 + {1'b0, ks, 1'b0};
   assign nr = 4'd10 + {1'b0, ks, 1'b0};

   always_comb begin
      k256 = '0;
      k256[255 -: MAX_KEY_BITS] = bus.in_key;
      req = bus.key_size;
`ifdef AES_ERR_EN
      bad = (req == 2'd3) || (req > MAX_SZ);
`else
      if (req == 2'd3) req = 2'd0;
      if (req > MAX_SZ) req = MAX_SZ;
`endif
      unique case (req)
         2'd0:    kl = k256 >> 128;
         2'd1:    kl = k256 >> 64;
         default: kl = k256;
      endcase
   end

   // win holds the newest 8 schedule words; g extends it by 4 more
   always_comb begin
      logic [3:0]  s;
      logic [3:0]  rot, sub;
      logic [31:0] prev, sin, sw, t;
      int          o;
      rot = '0;
      sub = '0;
      for (int k = 0; k < 4; k++) begin
         s = {1'b0, ph} + 4'(k);
         rot[k] = (s == 4'd0) || (s == nk);
         sub[k] = (nk == 4'd8) && (s == 4'd4);
      end
      o = 8 - int'(nk);
      prev = win[7];
      sin = win[7];
      for (int k = 0; k < 4; k++) begin
         if (rot[k]) sin = {prev[23:0], prev[31:24]};
         else if (sub[k]) sin = prev;
         g[k] = win[o+k] ^ prev;
         prev = g[k];
      end
      sw = subw(sin);
      prev = win[7];
      for (int k = 0; k < 4; k++) begin
         t = prev;
         if (rot[k]) t = sw ^ {rcon, 24'h0};
         else if (sub[k]) t = sw;
         g[k] = win[o+k] ^ t;
         prev = g[k];
      end
      for (int j = 0; j < 8; j++) cat[j] = win[j];
      for (int j = 0; j < 4; j++) cat[8+j] = g[j];
      o = 12 - int'(nk);
      rk = {cat[o], cat[o+1], cat[o+2], cat[o+3]};
      rot_any = |rot;
      s = {1'b0, ph} + 4'd4;
      if (s >= nk) s = s - nk;
      ph_nxt = s[2:0];
   end

   always_comb begin
      logic [7:0]   sb [16];
      logic [7:0]   sr [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] mix;
      for (int i = 0; i < 16; i++) sb[i] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[4*c+r] = sb[4*((c+r)%4)+r];
      mix = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         if (rnd == nr)
            mix[127-32*c -: 32] = {a0, a1, a2, a3};
         else
            mix[127-32*c -: 32] = {
               xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      nxt = mix ^ rk;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm  <= IDLE;
         rnd  <= '0;
         ks   <= '0;
         ph   <= '0;
         rcon <= 8'h01;
         st   <= '0;
         rdy  <= 1'b1;
         vld  <= 1'b0;
         bsy  <= 1'b0;
`ifdef AES_ERR_EN
         err  <= 1'b0;
`endif
         for (int p = 0; p < 8; p++) win[p] <= '0;
      end else begin
         unique case (fsm)
            IDLE: if (bus.in_valid) begin
               rdy <= 1'b0;
               bsy <= 1'b1;
`ifdef AES_ERR_EN
               if (bad) begin
                  fsm <= DONE;
                  st  <= '0;
                  err <= 1'b1;
                  vld <= 1'b1;
               end else
`endif
               begin
                  fsm  <= ROUND;
                  st   <= bus.in_data ^ k256[255:128];
                  ks   <= req;
                  ph   <= '0;
                  rcon <= 8'h01;
                  rnd  <= 4'd1;
                  for (int p = 0; p < 8; p++)
                     win[p] <= kl[255-32*p -: 32];
               end
            end
            ROUND: begin
               st  <= nxt;
               ph  <= ph_nxt;
               rnd <= rnd + 4'd1;
               if (rot_any) rcon <= xtime(rcon);
               for (int p = 0; p < 8; p++) win[p] <= cat[p+4];
               if (rnd == nr) begin
                  fsm <= DONE;
                  vld <= 1'b1;
               end
            end
            DONE: if (bus.out_ready) begin
               fsm <= IDLE;
               vld <= 1'b0;
               rdy <= 1'b1;
               bsy <= 1'b0;
`ifdef AES_ERR_EN
               err <= 1'b0;
`endif
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = vld;
   assign bus.out_data  = st;
   assign bus.busy      = bsy;
`ifdef AES_ERR_EN
   assign bus.err       = err;
`endif
endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: FIPS-197 vectors, stalls, reset, random blocks.
// Reference cipher uses a full key expansion and a table S-box.
module tb_aes_iter_core;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K128 =
      {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 =
      {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic [0:2047] sbt = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16};

   aes_iter_core_if #(.MAX_KEY_BITS(256)) bus ();

   aes_iter_core #(.MAX_KEY_BITS(256)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sb(input logic [7:0] x);
      return sbt[8*int'(x) +: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] x);
      return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   function automatic logic [7:0] cmul(input int k, input logic [7:0] x);
      if (k == 2) return xt(x);
      if (k == 3) return xt(x) ^ x;
      return x;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                            input logic [255:0] key,
                                            input int ksz);
      logic [31:0]  w [60];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] res;
      int nk, nr, cf;
      nk = 4 + 2 * ksz;
      nr = nk + 6;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      rc = 8'h01;
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk == 8 && i % nk == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int i = 0; i < 16; i++)
         s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++)
            t[i] = sb(s[(i + 4 * (i % 4)) % 16]);
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
               if (r == nr) begin
                  s[4*c+row] = t[4*c+row];
               end else begin
                  s[4*c+row] = 8'h00;
                  for (int j = 0; j < 4; j++) begin
                     cf = (j == row) ? 2 : (j == (row + 1) % 4) ? 3 : 1;
                     s[4*c+row] ^= cmul(cf, t[4*c+j]);
                  end
               end
            end
         for (int i = 0; i < 16; i++)
            s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic send(input logic [127:0] pt, input logic [255:0] key,
                       input logic [1:0] ksz, input int hold,
                       output logic [127:0] ct, output int lat,
                       output logic err);
      int n;
      logic ok;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = pt;
      bus.in_key   = key;
      bus.key_size = ksz;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", bus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.in_key   = {8{$urandom}};
      bus.key_size = 2'($urandom);
      chk("busy_after_accept", {bus.busy, bus.in_ready}, 2'b10);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      ct = bus.out_data;
`ifdef AES_ERR_EN
      err = bus.err;
`else
      err = 1'b0;
`endif
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!bus.out_valid || bus.out_data !== ct || bus.in_ready)
            ok = 1'b0;
      end
      if (hold > 0) chk("stall_hold", ok, 1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("ready_after_out", {bus.in_ready, bus.out_valid}, 2'b10);
`ifdef AES_ERR_EN
      chk("err_clear", bus.err, 0);
`endif
   endtask

   logic [127:0] ct, exp;
   int           lat, eff;
   logic         e;
   logic [1:0]   rks;
   logic [255:0] rkey;
   logic [127:0] rpt;
   logic         ok;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_key    = '0;
      bus.key_size  = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state",
          {bus.in_ready, bus.out_valid, bus.busy, bus.out_data},
          {1'b1, 1'b0, 1'b0, 128'h0});
`ifdef AES_ERR_EN
      chk("reset_err", bus.err, 0);
`endif
      rst_n = 1'b1;

      send(PT, K128, 2'd0, 0, ct, lat, e);
      chk("kat128", ct, C128);
      chk("lat128", lat, 11);
      send(PT, K192, 2'd1, 0, ct, lat, e);
      chk("kat192", ct, C192);
      chk("lat192", lat, 13);
      send(PT, K256, 2'd2, 0, ct, lat, e);
      chk("kat256", ct, C256);
      chk("lat256", lat, 15);

      send(PT, K128, 2'd0, 20, ct, lat, e);
      chk("stall128", ct, C128);
      send(PT, K256, 2'd2, 0, ct, lat, e);
      chk("b2b_256", ct, C256);
      send(PT, K128, 2'd0, 0, ct, lat, e);
      chk("b2b_128", ct, C128);

      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = PT;
      bus.in_key   = K128;
      bus.key_size = 2'd0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_state", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid) ok = 1'b0;
      end
      chk("midrst_no_out", ok, 1);
      send(PT, K128, 2'd0, 0, ct, lat, e);
      chk("after_rst128", ct, C128);

      send(PT, K128, 2'd3, 0, ct, lat, e);
`ifdef AES_ERR_EN
      chk("illegal_out", ct, 0);
      chk("illegal_lat", lat, 1);
      chk("illegal_err", e, 1);
`else
      chk("illegal_as128", ct, C128);
      chk("illegal_lat", lat, 11);
`endif

      for (int n = 0; n < 24; n++) begin
         rks  = 2'($urandom_range(0, 3));
         rpt  = {$urandom, $urandom, $urandom, $urandom};
         rkey = {8{$urandom}};
         send(rpt, rkey, rks, $urandom_range(0, 3), ct, lat, e);
         eff = (rks == 2'd3) ? 0 : int'(rks);
`ifdef AES_ERR_EN
         if (rks == 2'd3) begin
            chk("rand_err", {e, ct}, {1'b1, 128'h0});
            chk("rand_err_lat", lat, 1);
            continue;
         end
`endif
         exp = aes_ref(rpt, rkey, eff);
         chk("rand_ct", ct, exp);
         chk("rand_lat", lat, 11 + 2 * eff);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
